instruction_fetch: RTL
======================

Name: instruction_fetch

Overview:
- Fetch stage directly upstream of the 64-word combinational instruction_memory.
- Owns the PC and drives the word address into the memory.
- Captures the returned 32-bit instruction into an IF/ID output register, with a valid/ready handshake toward decode.
- Handles branch redirects from execute, detects the halt idiom `beq x0,x0,#0`, and flags misaligned or out-of-range PCs.

Parameters:
- PC_W, 64, width of the byte-addressed PC.
- ADDR_W, 6, instruction-memory word-address width (2^ADDR_W words).
- RESET_PC, 0, byte address of the first fetch after reset.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- i_mem_addr  out  ADDR_W  word index into instruction_memory, equal to pc[ADDR_W+1:2].
- i_mem_data  in  32  instruction read combinationally from memory.
- redirect_valid  in  1  execute requests a PC change (taken branch or jump).
- redirect_pc  in  PC_W  byte target of the redirect.
- out_valid  out  1  IF/ID register holds an instruction.
- out_ready  in  1  decode accepts the instruction this cycle.
- out_instr  out  32  fetched instruction.
- out_pc  out  PC_W  byte PC of out_instr.
- halted  out  1  halt idiom fetched; fetch is stopped.
- fault  out  1  sticky flag: misaligned or out-of-range PC.

Behaviour:
- Reset (async assert, applies immediately):
  - pc=RESET_PC, state=RUN.
  - out_valid=0, out_instr=0, out_pc=0, halted=0, fault=0.
- i_mem_addr is combinational from pc in every state.
- States:
  - RUN: fetching.
  - HALT: halt idiom issued; no further fetches.
  - FAULT: bad PC; frozen.
- Advance condition in RUN: adv = (!out_valid || out_ready).
- Priority per clock edge in RUN: redirect, then adv, then hold.
- redirect_valid=1 in RUN:
  - Flushes the output register: out_valid<=0.
  - pc<=redirect_pc.
  - A same-cycle out_valid&&out_ready transfer still counts as delivered.
- Redirect target check:
  - If redirect_pc[1:0]!=0, or redirect_pc[PC_W-1:ADDR_W+2]!=0, then state<=FAULT and fault<=1.
  - pc still loads the target, for debug visibility.
- adv=1 and no redirect in RUN:
  - out_instr<=i_mem_data, out_pc<=pc, out_valid<=1, pc<=pc+4.
  - PC addition is modulo 2^PC_W.
- Running off the end of memory: pc+4 landing at 4*2^ADDR_W does not wrap. It goes to FAULT at the next fetch attempt, with no instruction issued.
- Halt idiom: if the captured instruction equals HALT_INSTR (32'h00000063), state<=HALT and halted<=1 in the same edge. The halt instruction itself is delivered.
- adv=0 (backpressure): pc, out_instr, out_pc and out_valid are all held stable.
- HALT:
  - redirect_valid is ignored and no fetch occurs.
  - out_valid clears once the pending instruction is accepted.
  - Only reset exits HALT.
- FAULT:
  - out_valid<=0 and no fetch occurs.
  - redirect_valid is ignored.
  - Only reset exits FAULT.
- Latency:
  - First out_valid=1 at the first rising edge after rst_n deasserts.
  - Redirect costs exactly one bubble cycle.
- Reset asserted mid-stall or mid-redirect: all state returns to reset values immediately, with no partial transfer.

Decomposition:
- Package fetch_pkg contains:
  - fetch_state_t enum {RUN, HALT, FAULT}.
  - HALT_INSTR.
  - OPC_BRANCH=7'b1100011.
  - The pc_ok(pc) range/alignment check as a function.
- One sub-module, ifid_reg: the valid/ready output register with flush input. The PC and FSM stay in instruction_fetch.

Test Plan:
- Reset streaming: reset, then out_ready=1 with memory preloaded words 0..4 → out_pc sequence 0,4,8,12,16 on consecutive cycles. out_instr matches mem[0..4]; i_mem_addr is 0,1,2,3,4.
- Backpressure: out_ready=0 for 3 cycles at out_pc=8 → out_instr, out_pc=8 and pc=12 are held. On release, the next beat has out_pc=12.
- Redirect: redirect_valid=1, redirect_pc=44 while out_pc=24 is valid → next cycle out_valid=0, then the following cycle out_pc=44 with mem[11].
- Halt: mem[14]=32'h00000063 reached → that beat is delivered with out_pc=56 and halted=1. Afterwards out_valid stays 0, and redirect_pc=0 is ignored.
- Faults:
  - redirect_pc=6 → fault=1, out_valid=0 thereafter.
  - Separately, sequential fetch past word 63 (pc=256) → fault=1, with no beat at out_pc=256.
- Async reset mid-stall: rst_n=0 while out_valid=1 and out_ready=0 → out_valid=0, pc=0 immediately. After release, streaming restarts at out_pc=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   fetch_state_t : RUN (fetching), HALT (halt idiom issued), FAULT (bad PC, frozen)
//   OPC_BRANCH    : RV32 branch major opcode
//   HALT_INSTR    : beq x0,x0,#0, the self-loop used as a halt marker
//   pc_ok()       : alignment and range check of a byte PC against the memory size
package fetch_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    // beq x0,x0,#0 has every field zero except the opcode
    localparam logic [31:0] HALT_INSTR = {25'd0, OPC_BRANCH};

    // Widest PC the range check supports; narrower PCs are zero-extended.
    localparam int MAX_PC_W = 64;

    // A PC is usable when it is word aligned and every bit above the
    // word-address field is zero, i.e. it points inside the memory.
    function automatic logic pc_ok(input logic [MAX_PC_W-1:0] pc, input int addr_w);
        return (pc[1:0] == 2'b00) && ((pc >> (addr_w + 2)) == '0);
    endfunction

endpackage

// File: rtl/instruction_fetch_ifid_reg.sv
// IF/ID pipeline register with a valid/ready handshake.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : capture instr_in/pc_in and mark the register valid
//   flush       : drop the held instruction (wins over load)
//   pop         : consumer accepted the held instruction this cycle
//   instr_in    : instruction to capture
//   pc_in       : byte PC of instr_in
//   valid       : register holds an instruction
//   instr, pc   : held instruction and its byte PC
module ifid_reg
    import fetch_pkg::*;
#(
    parameter int PC_W = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            flush,
    input  logic            pop,
    input  logic [31:0]     instr_in,
    input  logic [PC_W-1:0] pc_in,
    output logic            valid,
    output logic [31:0]     instr,
    output logic [PC_W-1:0] pc
);

    // Flush only clears valid; the stale payload is harmless once invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= instr_in;
            pc    <= pc_in;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage feeding decode from a combinational instruction memory.
//   clk, rst_n     : clock, asynchronous active-low reset
//   i_mem_addr     : word index into instruction memory (pc[ADDR_W+1:2])
//   i_mem_data     : instruction returned combinationally by the memory
//   redirect_valid : execute requests a PC change
//   redirect_pc    : byte target of that change
//   out_valid      : IF/ID register holds an instruction
//   out_ready      : decode accepts the instruction this cycle
//   out_instr      : fetched instruction
//   out_pc         : byte PC of out_instr
//   halted         : halt idiom fetched, fetching stopped
//   fault          : sticky, a misaligned or out-of-range PC was seen
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int              PC_W     = 64,
    parameter int              ADDR_W   = 6,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] i_mem_addr,
    input  logic [31:0]       i_mem_data,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [PC_W-1:0]   out_pc,
    output logic              halted,
    output logic              fault
);

    fetch_state_t    state, state_next;
    logic [PC_W-1:0] pc, pc_next;
    logic            adv;
    logic            load;
    logic            flush;

    assign i_mem_addr = pc[ADDR_W+1:2];
    assign adv        = !out_valid || out_ready;
    assign halted     = (state == HALT);
    assign fault      = (state == FAULT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // A redirect always loads the target PC, even a bad one, so the
    // offending address stays visible while frozen in FAULT. Running off
    // the end of memory is caught at the fetch attempt, so the bad PC is
    // never issued as a beat.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        load       = 1'b0;
        flush      = 1'b0;
        case (state)
            RUN: begin
                if (redirect_valid) begin
                    flush   = 1'b1;
                    pc_next = redirect_pc;
                    if (!pc_ok(MAX_PC_W'(redirect_pc), ADDR_W)) begin
                        state_next = FAULT;
                    end
                end else if (adv) begin
                    if (!pc_ok(MAX_PC_W'(pc), ADDR_W)) begin
                        flush      = 1'b1;
                        state_next = FAULT;
                    end else begin
                        load    = 1'b1;
                        pc_next = pc + PC_W'(4);
                        if (i_mem_data == HALT_INSTR) begin
                            state_next = HALT;
                        end
                    end
                end
            end
            HALT: begin
            end
            FAULT: begin
                flush = 1'b1;
            end
            default: begin
                flush      = 1'b1;
                state_next = FAULT;
            end
        endcase
    end

    ifid_reg #(
        .PC_W(PC_W)
    ) u_ifid (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .flush    (flush),
        .pop      (out_ready),
        .instr_in (i_mem_data),
        .pc_in    (pc),
        .valid    (out_valid),
        .instr    (out_instr),
        .pc       (out_pc)
    );

endmodule
